gpio_bank: RTL and testbench
============================

// Module: gpio_bank
// PURPOSE
//  Parametrised GPIO bank for the j1 IO space. It replaces the fixed 8-bit in/out/dir triplets.
//  - Input synchronisers of configurable depth.
//  - Atomic set/clear/toggle of output bits.
//  - Per-bit rising/falling edge capture with sticky pending bits and a masked interrupt.
//  - Instanced once per PMOD/header bank; top decodes the bank's one-hot mem_addr bit into cs.
// PARAMETERS
//  WIDTH        8  pins in bank, 1..16; register bits [15:WIDTH] read 0, writes ignored
//  SYNC_STAGES  2  input synchroniser flops, >=2
//  RESET_OUT    0  reset value of OUT[WIDTH-1:0]
//  RESET_DIR    0  reset value of DIR (1:output, 0:input)
// PORTS
//  clk      in   1      system clock
//  resetq   in   1      asynchronous, active-low reset
//  cs       in   1      bank select (one-hot mem_addr bit decoded by top)
//  io_rd    in   1      IO read strobe, one cycle
//  io_wr    in   1      IO write strobe, one cycle
//  reg_sel  in   10     one-hot register select within bank (mem_addr[9:0])
//  wdata    in   16     write data (j1 dout)
//  rdata    out  16     read data, combinational; 0 when !cs
//  pin_in   in   WIDTH  raw pad inputs (SB_IO D_IN_0)
//  pin_out  out  WIDTH  OUT register to pads (D_OUT_0)
//  pin_dir  out  WIDTH  DIR register to pads (OUTPUT_ENABLE)
//  irq      out  1      registered interrupt, level
// BEHAVIOUR
//  Register map (reg_sel bit: name, access):
//   0 IN RO (synchronised); 1 OUT RW; 2 DIR RW; 3 OUT_SET WO; 4 OUT_CLR WO; 5 OUT_TGL WO;
//   6 RISE_EN RW; 7 FALL_EN RW; 8 PEND R/W1C; 9 IRQ_EN RW.
//  - Writes occur on the clk edge when cs&io_wr; every selected register is written.
//  - Reads: rdata = OR of all selected readable registers; WO registers read 0; io_rd has no side effect.
//  - Reset values: OUT=RESET_OUT, DIR=RESET_DIR; RISE_EN, FALL_EN, PEND, IRQ_EN, sync chain, prev and irq = 0.
//  - OUT update in one write, with w=wdata[WIDTH-1:0]:
//      OUT <= (((sel1 ? w : OUT) | (sel3 ? w : 0)) & ~(sel4 ? w : 0)) ^ (sel5 ? w : 0)
//  - Sync: s[0]<=pin_in, s[i]<=s[i-1]. IN = s[SYNC_STAGES-1]; prev <= IN each cycle.
//  - Edges: rise = IN & ~prev & RISE_EN; fall = ~IN & prev & FALL_EN.
//  - PEND next = (PEND & ~(W1C mask)) | rise | fall. A new edge wins over a same-cycle W1C of that bit.
//  - Latency: a pin change before edge 0 is visible in IN after edge SYNC_STAGES.
//    PEND sets at edge SYNC_STAGES+1; irq asserts at edge SYNC_STAGES+2.
//  - irq <= |(PEND & IRQ_EN), registered. Clearing PEND or IRQ_EN drops irq one cycle later.
//  - Warm-up: a counter of SYNC_STAGES+1 cycles runs after reset release.
//    Until it expires, rise/fall are forced 0, so pins high at reset give no false edges.
//  - Reset assertion mid-operation clears all state immediately (async), including the warm-up counter.
//  - Edge detection ignores DIR: output pins read back through pad, and their edges capture too.
//  - Enabling RISE_EN while IN is already high does not set PEND; only transitions count.
// TESTING
//  1 Reset with RESET_OUT=8'hA5, pin_in=8'hFF -> pin_out=A5, pin_dir=00, PEND stays 0 after warm-up, irq=0.
//  2 OUT=0F, then OUT_SET=F0, OUT_CLR=03, OUT_TGL=81 -> OUT sequence FF, FC, 7D; IN reads pin_in after 2 clk.
//  3 RISE_EN=01, IRQ_EN=01, pin0 0->1 -> PEND=01 at edge 3, irq=1 at edge 4. Write PEND=01 -> irq=0 next cycle.
//  4 FALL_EN=80, pin7 falls in the same cycle as a W1C write of PEND=80 -> PEND[7] remains 1.
//  5 WIDTH=5, write FFFF to OUT -> OUT/rdata=001F. cs=0 with io_wr -> no change; cs=0 read -> 0000.
//  6 reg_sel=0x006 read with OUT=0x12, DIR=0x30 -> rdata=0x32. Async reset mid-edge -> PEND=0, irq=0 at once.

Source files
------------

// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO bank for the j1 IO space.
//   Input synchronisers, atomic set/clear/toggle of OUT, per-bit rise/fall
//   edge capture into sticky PEND bits, and a masked level interrupt.
// Ports:
//   clk, resetq          clock, asynchronous active-low reset
//   cs, io_rd, io_wr     bank select and one-cycle IO strobes
//   reg_sel[9:0]         one-hot register select within the bank
//   wdata[15:0]          write data
//   rdata[15:0]          combinational read data, 0 when !cs
//   pin_in/out/dir       pad input, OUT register, DIR register (WIDTH bits)
//   irq                  registered level interrupt
module gpio_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] RESET_OUT   = 16'h0000,
  parameter logic [15:0] RESET_DIR   = 16'h0000
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cs,
  input  logic             io_rd,
  input  logic             io_wr,
  input  logic [9:0]       reg_sel,
  input  logic [15:0]      wdata,
  output logic [15:0]      rdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_dir,
  output logic             irq
);

  localparam int unsigned SEL_IN   = 0;
  localparam int unsigned SEL_OUT  = 1;
  localparam int unsigned SEL_DIR  = 2;
  localparam int unsigned SEL_SET  = 3;
  localparam int unsigned SEL_CLR  = 4;
  localparam int unsigned SEL_TGL  = 5;
  localparam int unsigned SEL_RISE = 6;
  localparam int unsigned SEL_FALL = 7;
  localparam int unsigned SEL_PEND = 8;
  localparam int unsigned SEL_IEN  = 9;

  localparam int unsigned WARM_CYC = SYNC_STAGES + 1;
  localparam int unsigned WARM_W   = $clog2(WARM_CYC + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]  r_prev;
  logic [WIDTH-1:0]  r_out;
  logic [WIDTH-1:0]  r_dir;
  logic [WIDTH-1:0]  r_rise_en;
  logic [WIDTH-1:0]  r_fall_en;
  logic [WIDTH-1:0]  r_pend;
  logic [WIDTH-1:0]  r_irq_en;
  logic              r_irq;
  logic [WARM_W-1:0] r_warm;

  logic              w_wr;
  logic [WIDTH-1:0]  w_w;
  logic [WIDTH-1:0]  w_in;
  logic              w_warm_done;
  logic [WIDTH-1:0]  w_rise;
  logic [WIDTH-1:0]  w_fall;
  logic [WIDTH-1:0]  w_w1c;
  logic [WIDTH-1:0]  w_out_nxt;
  logic [WIDTH-1:0]  w_rd;
  logic              w_unused;

  assign w_wr        = cs & io_wr;
  assign w_w         = wdata[WIDTH-1:0];
  assign w_in        = r_sync[SYNC_STAGES-1];
  assign w_warm_done = (r_warm == WARM_W'(WARM_CYC));

  // Edges are suppressed until the sync chain and prev hold real pad values
  assign w_rise = w_warm_done ? (w_in & ~r_prev & r_rise_en) : '0;
  assign w_fall = w_warm_done ? (~w_in & r_prev & r_fall_en) : '0;
  assign w_w1c  = (w_wr && reg_sel[SEL_PEND]) ? w_w : '0;

  // io_rd has no side effect; upper wdata bits unused when WIDTH < 16
  assign w_unused = &{1'b0, io_rd, wdata};

  // OUT next value: load, then set, clear, toggle in that order
  always_comb begin
    w_out_nxt = reg_sel[SEL_OUT] ? w_w : r_out;
    if (reg_sel[SEL_SET]) w_out_nxt = w_out_nxt | w_w;
    if (reg_sel[SEL_CLR]) w_out_nxt = w_out_nxt & ~w_w;
    if (reg_sel[SEL_TGL]) w_out_nxt = w_out_nxt ^ w_w;
  end

  // Read mux: OR of every selected readable register
  always_comb begin
    w_rd = '0;
    if (reg_sel[SEL_IN])   w_rd = w_rd | w_in;
    if (reg_sel[SEL_OUT])  w_rd = w_rd | r_out;
    if (reg_sel[SEL_DIR])  w_rd = w_rd | r_dir;
    if (reg_sel[SEL_RISE]) w_rd = w_rd | r_rise_en;
    if (reg_sel[SEL_FALL]) w_rd = w_rd | r_fall_en;
    if (reg_sel[SEL_PEND]) w_rd = w_rd | r_pend;
    if (reg_sel[SEL_IEN])  w_rd = w_rd | r_irq_en;
  end

  assign rdata = cs ? 16'(w_rd) : 16'h0000;

  // Input synchroniser, previous-value register and warm-up counter
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_sync <= '0;
      r_prev <= '0;
      r_warm <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pin_in};
      r_prev <= w_in;
      if (!w_warm_done) r_warm <= r_warm + WARM_W'(1);
    end
  end

  // Software-visible registers
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_out     <= RESET_OUT[WIDTH-1:0];
      r_dir     <= RESET_DIR[WIDTH-1:0];
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_irq_en  <= '0;
    end else if (w_wr) begin
      r_out <= w_out_nxt;
      if (reg_sel[SEL_DIR])  r_dir     <= w_w;
      if (reg_sel[SEL_RISE]) r_rise_en <= w_w;
      if (reg_sel[SEL_FALL]) r_fall_en <= w_w;
      if (reg_sel[SEL_IEN])  r_irq_en  <= w_w;
    end
  end

  // Sticky pending bits (new edge beats W1C) and registered interrupt
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_pend <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_w1c) | w_rise | w_fall;
      r_irq  <= |(r_pend & r_irq_en);
    end
  end

  assign pin_out = r_out;
  assign pin_dir = r_dir;
  assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_bank.sv
// tb_gpio_bank: directed self-checking bench for gpio_bank.
//   u_dut8: WIDTH=8, RESET_OUT=A5; u_dut5: WIDTH=5. Shared bus, separate cs.
module tb_gpio_bank;

  localparam logic [9:0] R_IN   = 10'h001;
  localparam logic [9:0] R_OUT  = 10'h002;
  localparam logic [9:0] R_DIR  = 10'h004;
  localparam logic [9:0] R_SET  = 10'h008;
  localparam logic [9:0] R_CLR  = 10'h010;
  localparam logic [9:0] R_TGL  = 10'h020;
  localparam logic [9:0] R_RISE = 10'h040;
  localparam logic [9:0] R_FALL = 10'h080;
  localparam logic [9:0] R_PEND = 10'h100;
  localparam logic [9:0] R_IEN  = 10'h200;

  logic        clk;
  logic        resetq;
  logic        cs8;
  logic        cs5;
  logic        io_rd;
  logic        io_wr;
  logic [9:0]  reg_sel;
  logic [15:0] wdata;
  logic [15:0] rdata8;
  logic [15:0] rdata5;
  logic [7:0]  pin_in8;
  logic [7:0]  pin_out8;
  logic [7:0]  pin_dir8;
  logic        irq8;
  logic [4:0]  pin_in5;
  logic [4:0]  pin_out5;
  logic [4:0]  pin_dir5;
  logic        irq5;

  int n_checks;
  int n_errors;

  gpio_bank #(.WIDTH(8), .SYNC_STAGES(2), .RESET_OUT(16'h00A5), .RESET_DIR(16'h0000)) u_dut8 (
    .clk(clk), .resetq(resetq), .cs(cs8), .io_rd(io_rd), .io_wr(io_wr),
    .reg_sel(reg_sel), .wdata(wdata), .rdata(rdata8),
    .pin_in(pin_in8), .pin_out(pin_out8), .pin_dir(pin_dir8), .irq(irq8)
  );

  gpio_bank #(.WIDTH(5), .SYNC_STAGES(2), .RESET_OUT(16'h0000), .RESET_DIR(16'h0000)) u_dut5 (
    .clk(clk), .resetq(resetq), .cs(cs5), .io_rd(io_rd), .io_wr(io_wr),
    .reg_sel(reg_sel), .wdata(wdata), .rdata(rdata5),
    .pin_in(pin_in5), .pin_out(pin_out5), .pin_dir(pin_dir5), .irq(irq5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write strobe committed on the next rising edge
  task automatic bus_wr(input logic s8, input logic s5, input logic [9:0] sel, input logic [15:0] d);
    cs8 = s8; cs5 = s5; io_wr = 1'b1; reg_sel = sel; wdata = d;
    @(posedge clk);
    #1;
    cs8 = 1'b0; cs5 = 1'b0; io_wr = 1'b0; reg_sel = '0; wdata = '0;
  endtask

  task automatic rd8(input logic [9:0] sel, output logic [15:0] d);
    cs8 = 1'b1; io_rd = 1'b1; reg_sel = sel;
    #1;
    d = rdata8;
    cs8 = 1'b0; io_rd = 1'b0; reg_sel = '0;
  endtask

  task automatic rd5(input logic [9:0] sel, output logic [15:0] d);
    cs5 = 1'b1; io_rd = 1'b1; reg_sel = sel;
    #1;
    d = rdata5;
    cs5 = 1'b0; io_rd = 1'b0; reg_sel = '0;
  endtask

  logic [15:0] v;

  initial begin
    n_checks = 0; n_errors = 0;
    resetq = 1'b0; cs8 = 1'b0; cs5 = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    reg_sel = '0; wdata = '0; pin_in8 = 8'hFF; pin_in5 = 5'h00;

    // Reset values with pins high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pin_out", 16'(pin_out8), 16'h00A5);
    chk("rst_pin_dir", 16'(pin_dir8), 16'h0000);
    chk("rst_irq", 16'(irq8), 16'h0000);
    resetq = 1'b1;
    // Enable both edge types on the very first edge: warm-up must hide the 0->FF sync fill
    bus_wr(1'b1, 1'b0, R_RISE | R_FALL, 16'h00FF);
    repeat (5) tick();
    rd8(R_PEND, v); chk("warm_pend", v, 16'h0000);
    chk("warm_irq", 16'(irq8), 16'h0000);
    rd8(R_IN, v); chk("warm_in", v, 16'h00FF);
    bus_wr(1'b1, 1'b0, R_RISE | R_FALL, 16'h0000);

    // OUT set/clear/toggle
    bus_wr(1'b1, 1'b0, R_OUT, 16'h000F); chk("out_ld", 16'(pin_out8), 16'h000F);
    bus_wr(1'b1, 1'b0, R_SET, 16'h00F0); chk("out_set", 16'(pin_out8), 16'h00FF);
    bus_wr(1'b1, 1'b0, R_CLR, 16'h0003); chk("out_clr", 16'(pin_out8), 16'h00FC);
    bus_wr(1'b1, 1'b0, R_TGL, 16'h0081); chk("out_tgl", 16'(pin_out8), 16'h007D);
    // Set and clear of the same bits together: clear wins -> 7D & F0
    bus_wr(1'b1, 1'b0, R_SET | R_CLR, 16'h000F); chk("out_setclr", 16'(pin_out8), 16'h0070);
    rd8(R_OUT, v); chk("out_rd", v, 16'h0070);
    rd8(R_SET | R_CLR | R_TGL, v); chk("wo_rd", v, 16'h0000);

    // IN latency through the synchroniser
    pin_in8 = 8'h5A;
    tick(); rd8(R_IN, v); chk("in_lat1", v, 16'h00FF);
    tick(); rd8(R_IN, v); chk("in_lat2", v, 16'h005A);

    // Rising edge on pin0 -> PEND at edge 3, irq at edge 4, W1C drops irq one cycle later
    bus_wr(1'b1, 1'b0, R_RISE | R_IEN, 16'h0001);
    pin_in8 = 8'h5B;
    tick(); chk("rise_irq_e1", 16'(irq8), 16'h0000);
    tick(); rd8(R_PEND, v); chk("rise_pend_e2", v, 16'h0000);
    tick(); rd8(R_PEND, v); chk("rise_pend_e3", v, 16'h0001);
    chk("rise_irq_e3", 16'(irq8), 16'h0000);
    tick(); chk("rise_irq_e4", 16'(irq8), 16'h0001);
    bus_wr(1'b1, 1'b0, R_PEND, 16'h0001);
    rd8(R_PEND, v); chk("w1c_pend", v, 16'h0000);
    chk("w1c_irq_same", 16'(irq8), 16'h0001);
    tick(); chk("w1c_irq_next", 16'(irq8), 16'h0000);

    // Enabling RISE_EN on an already-high pin must not set PEND
    bus_wr(1'b1, 1'b0, R_RISE, 16'h0002);
    repeat (4) tick();
    rd8(R_PEND, v); chk("rise_en_level", v, 16'h0000);
    bus_wr(1'b1, 1'b0, R_RISE, 16'h0000);

    // Falling edge on pin7, then a second fall coinciding with W1C of that bit
    bus_wr(1'b1, 1'b0, R_FALL, 16'h0080);
    pin_in8 = 8'hDB; repeat (4) tick();
    rd8(R_PEND, v); chk("fall_rise_ign", v, 16'h0000);
    pin_in8 = 8'h5B; repeat (3) tick();
    rd8(R_PEND, v); chk("fall_pend", v, 16'h0080);
    chk("fall_irq_masked", 16'(irq8), 16'h0000);
    pin_in8 = 8'hDB; repeat (4) tick();
    pin_in8 = 8'h5B; tick(); tick();
    bus_wr(1'b1, 1'b0, R_PEND, 16'h0080);
    rd8(R_PEND, v); chk("edge_beats_w1c", v, 16'h0080);
    tick();
    bus_wr(1'b1, 1'b0, R_PEND, 16'h0080);
    rd8(R_PEND, v); chk("w1c_no_edge", v, 16'h0000);

    // WIDTH=5 bank, and cs gating of the 8-bit bank
    bus_wr(1'b0, 1'b1, R_OUT, 16'hFFFF);
    chk("w5_pin_out", 16'(pin_out5), 16'h001F);
    rd5(R_OUT, v); chk("w5_rd_out", v, 16'h001F);
    chk("cs0_no_wr", 16'(pin_out8), 16'h0070);
    reg_sel = R_OUT; #1;
    chk("cs0_rd", rdata8, 16'h0000);
    reg_sel = '0;

    // Multi-select read
    bus_wr(1'b1, 1'b0, R_OUT, 16'h0012);
    bus_wr(1'b1, 1'b0, R_DIR, 16'h0030);
    chk("dir_pin", 16'(pin_dir8), 16'h0030);
    rd8(R_OUT | R_DIR, v); chk("multi_rd", v, 16'h0032);

    // Async reset mid-cycle with PEND and irq active
    pin_in8 = 8'hDB; repeat (4) tick();
    pin_in8 = 8'h5B; repeat (3) tick();
    bus_wr(1'b1, 1'b0, R_IEN, 16'h0080);
    tick(); chk("pre_rst_irq", 16'(irq8), 16'h0001);
    #2;
    resetq = 1'b0;
    #1;
    chk("arst_irq", 16'(irq8), 16'h0000);
    rd8(R_PEND, v); chk("arst_pend", v, 16'h0000);
    chk("arst_out", 16'(pin_out8), 16'h00A5);
    chk("arst_dir", 16'(pin_dir8), 16'h0000);
    tick();
    resetq = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
